comm_slave: RTL and testbench

COMM_SLAVE -- requirements
Module: comm_slave

---
 rtl/comm_pkg.sv | 24 ++
 rtl/comm_slave_if.sv | 32 +++
 rtl/uart_rx.sv | 107 ++++++++++
 rtl/comm_slave.sv | 118 +++++++++++
 tb/tb_comm_slave.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/comm_pkg.sv
// comm_pkg
// Shared definitions for the command link (receive and transmit sides).
//   BAUD_DIV_DEFAULT : clk cycles per UART bit (50 MHz / 19200 baud)
//   TO_CYC_DEFAULT   : max clk cycles between the upper and lower byte of a command
//   cmd_state_e      : command assembly FSM states
//   rx_state_e       : byte receiver states
package comm_pkg;

   localparam int BAUD_DIV_DEFAULT = 2604;
   localparam int TO_CYC_DEFAULT   = 131072;

   typedef enum logic {
      IDLE,
      HIGH
   } cmd_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/comm_slave_if.sv
// comm_slave_if
// Serial line plus command handshake between the command receiver and its consumer.
//   RX          : UART serial line, idle high (asynchronous to clk)
//   clr_cmd_rdy : consumer acknowledge, clears cmd_rdy
//   cmd         : assembled 16-bit command, upper byte received first
//   cmd_rdy     : cmd holds a complete, unacknowledged command
//   frm_err     : one-cycle pulse on a bad stop bit or inter-byte timeout
interface comm_slave_if;

   logic        RX;
   logic        clr_cmd_rdy;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        frm_err;

   modport slave (
      input  RX,
      input  clr_cmd_rdy,
      output cmd,
      output cmd_rdy,
      output frm_err
   );

   modport master (
      output RX,
      output clr_cmd_rdy,
      input  cmd,
      input  cmd_rdy,
      input  frm_err
   );

endinterface

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 UART byte receiver. Expects an already synchronized serial input.
//   clk, rst_n : clock, asynchronous active-low reset
//   RX         : synchronized serial line, idle high
//   rx_data    : received byte, valid while rx_rdy is high
//   rx_rdy     : one-cycle pulse, byte received with a good stop bit
//   rx_err     : one-cycle pulse, stop bit sampled low (no rx_rdy)
module uart_rx
   import comm_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   output logic [7:0] rx_data,
   output logic       rx_rdy,
   output logic       rx_err
);

   localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             rx_prev_q, rx_prev_d;
   logic             rdy_q, rdy_d;
   logic             err_q, err_d;

   // The start state waits half a bit so every later sample, one full bit
   // apart, lands in the middle of its bit. A start bit that is high again
   // at that point was a glitch and is dropped silently.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q + 1'b1;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rx_prev_d  = RX;
      rdy_d      = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         RX_IDLE: begin
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            if (rx_prev_q && !RX) begin
               state_d = RX_START;
            end
         end
         RX_START: begin
            if (baud_cnt_q == HALF_M1) begin
               baud_cnt_d = '0;
               state_d    = RX ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (baud_cnt_q == FULL_M1) begin
               baud_cnt_d = '0;
               shift_d    = {RX, shift_q[7:1]};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            if (baud_cnt_q == FULL_M1) begin
               baud_cnt_d = '0;
               state_d    = RX_IDLE;
               if (RX) begin
                  rdy_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RX_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         rx_prev_q  <= 1'b1;
         rdy_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rx_prev_q  <= rx_prev_d;
         rdy_q      <= rdy_d;
         err_q      <= err_d;
      end
   end

   assign rx_data = shift_q;
   assign rx_rdy  = rdy_q;
   assign rx_err  = err_q;

endmodule

// File: rtl/comm_slave.sv
// comm_slave
// Receives two UART bytes (upper first) and presents them as a 16-bit command.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : comm_slave_if.slave -- RX, clr_cmd_rdy in; cmd, cmd_rdy, frm_err out
// Parameters: BAUD_DIV (clk cycles per bit), TO_CYC (inter-byte timeout in clk cycles).
module comm_slave
   import comm_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
   parameter int TO_CYC   = TO_CYC_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   comm_slave_if.slave bus
);

   localparam int TO_W = $clog2(TO_CYC + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_CYC);

   logic            rx_meta_q, rx_meta_d;
   logic            rx_sync_q, rx_sync_d;
   cmd_state_e      state_q, state_d;
   logic [7:0]      upper_q, upper_d;
   logic [15:0]     cmd_q, cmd_d;
   logic            cmd_rdy_q, cmd_rdy_d;
   logic            frm_err_q, frm_err_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   logic [7:0] rx_data;
   logic       rx_rdy;
   logic       rx_err;

   uart_rx #(
      .BAUD_DIV (BAUD_DIV)
   ) u_rx (
      .clk     (clk),
      .rst_n   (rst_n),
      .RX      (rx_sync_q),
      .rx_data (rx_data),
      .rx_rdy  (rx_rdy),
      .rx_err  (rx_err)
   );

   // An acknowledge is applied first so that a command completing in the
   // same cycle overrides it. A receive error abandons any half-built
   // command regardless of state; cmd itself only moves when both bytes
   // have arrived. The timeout counter stops at TO_MAX rather than wrapping.
   always_comb begin
      rx_meta_d = bus.RX;
      rx_sync_d = rx_meta_q;
      state_d   = state_q;
      upper_d   = upper_q;
      cmd_d     = cmd_q;
      cmd_rdy_d = cmd_rdy_q;
      frm_err_d = 1'b0;
      to_cnt_d  = to_cnt_q;
      if (bus.clr_cmd_rdy) begin
         cmd_rdy_d = 1'b0;
      end
      if (rx_err) begin
         state_d   = IDLE;
         upper_d   = '0;
         frm_err_d = 1'b1;
         to_cnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rx_rdy) begin
                  upper_d   = rx_data;
                  cmd_rdy_d = 1'b0;
                  to_cnt_d  = '0;
                  state_d   = HIGH;
               end
            end
            HIGH: begin
               if (rx_rdy) begin
                  cmd_d     = {upper_q, rx_data};
                  cmd_rdy_d = 1'b1;
                  state_d   = IDLE;
               end else if (to_cnt_q == TO_MAX) begin
                  frm_err_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  to_cnt_d = to_cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         state_q   <= IDLE;
         upper_q   <= '0;
         cmd_q     <= '0;
         cmd_rdy_q <= 1'b0;
         frm_err_q <= 1'b0;
         to_cnt_q  <= '0;
      end else begin
         rx_meta_q <= rx_meta_d;
         rx_sync_q <= rx_sync_d;
         state_q   <= state_d;
         upper_q   <= upper_d;
         cmd_q     <= cmd_d;
         cmd_rdy_q <= cmd_rdy_d;
         frm_err_q <= frm_err_d;
         to_cnt_q  <= to_cnt_d;
      end
   end

   assign bus.cmd     = cmd_q;
   assign bus.cmd_rdy = cmd_rdy_q;
   assign bus.frm_err = frm_err_q;

endmodule

// File: tb/tb_comm_slave.sv
// tb_comm_slave
// Directed bench for comm_slave with a short bit time and timeout.
module tb_comm_slave;

   localparam int BAUD = 16;
   localparam int TOC  = 200;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int check_count = 0;
   int pass_count  = 0;
   int fail_count  = 0;
   int err_count   = 0;
   int rdy_count   = 0;
   bit saw_1234    = 1'b0;

   always #5 clk = ~clk;

   comm_slave_if bus ();

   comm_slave #(
      .BAUD_DIV (BAUD),
      .TO_CYC   (TOC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Event monitors sampled away from the active edge
   always @(negedge clk) begin
      if (bus.frm_err) err_count++;
      if (dut.u_rx.rx_rdy) rdy_count++;
      if (bus.cmd == 16'h1234) saw_1234 = 1'b1;
   end

   task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      check_count++;
      assert (obs === exp) pass_count = pass_count + 1;
      else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one 8N1 frame; called and returns on a falling clock edge
   task automatic send_byte(input logic [7:0] data, input logic stop_bit);
      bus.RX = 1'b0;
      repeat (BAUD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.RX = data[i];
         repeat (BAUD) @(negedge clk);
      end
      bus.RX = stop_bit;
      repeat (BAUD) @(negedge clk);
      bus.RX = 1'b1;
   endtask

   task automatic wait_rx_rdy(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (dut.u_rx.rx_rdy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      int e0;
      int r0;
      bus.RX          = 1'b1;
      bus.clr_cmd_rdy = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check_output("reset_cmd", bus.cmd, 16'h0000);
      check_output("reset_cmd_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
      check_output("reset_frm_err", {15'd0, bus.frm_err}, 16'd0);
      rst_n = 1'b1;
      repeat (BAUD) @(negedge clk);

      // 0xA5 then 0x3C back-to-back
      send_byte(8'hA5, 1'b1);
      fork
         send_byte(8'h3C, 1'b1);
         begin
            wait_rx_rdy(BAUD * 12, ok);
            check_output("a53c_rx_rdy_seen", {15'd0, ok}, 16'd1);
            check_output("a53c_rdy_at_rx_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
            @(negedge clk);
            check_output("a53c_rdy_next", {15'd0, bus.cmd_rdy}, 16'd1);
            check_output("a53c_cmd", bus.cmd, 16'hA53C);
         end
      join
      check_output("a53c_no_frm_err", 16'(err_count), 16'd0);

      // Plain acknowledge clears cmd_rdy on the next edge
      bus.clr_cmd_rdy = 1'b1;
      @(negedge clk);
      bus.clr_cmd_rdy = 1'b0;
      check_output("clr_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
      check_output("clr_cmd_kept", bus.cmd, 16'hA53C);

      // Acknowledge coincident with the set: set wins
      send_byte(8'h11, 1'b1);
      fork
         send_byte(8'h22, 1'b1);
         begin
            wait_rx_rdy(BAUD * 12, ok);
            check_output("clr_set_rx_rdy_seen", {15'd0, ok}, 16'd1);
            bus.clr_cmd_rdy = 1'b1;
            @(negedge clk);
            bus.clr_cmd_rdy = 1'b0;
            check_output("clr_set_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
            check_output("clr_set_cmd", bus.cmd, 16'h1122);
         end
      join

      // New command overwrites with no acknowledge
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      repeat (2) @(negedge clk);
      check_output("overwrite_cmd", bus.cmd, 16'h3344);
      check_output("overwrite_rdy", {15'd0, bus.cmd_rdy}, 16'd1);

      // Inter-byte timeout
      e0 = err_count;
      send_byte(8'h12, 1'b1);
      repeat (TOC + 10) @(negedge clk);
      check_output("timeout_frm_err", 16'(err_count - e0), 16'd1);
      check_output("timeout_cmd_kept", bus.cmd, 16'h3344);
      check_output("timeout_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
      send_byte(8'h34, 1'b1);
      send_byte(8'h56, 1'b1);
      repeat (2) @(negedge clk);
      check_output("timeout_next_cmd", bus.cmd, 16'h3456);
      check_output("timeout_next_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
      check_output("timeout_single_err", 16'(err_count - e0), 16'd1);
      check_output("timeout_never_1234", {15'd0, saw_1234}, 16'd0);

      // Bad stop bit on the upper byte
      e0 = err_count;
      send_byte(8'hFF, 1'b0);
      repeat (2 * BAUD) @(negedge clk);
      check_output("stop_frm_err", 16'(err_count - e0), 16'd1);
      check_output("stop_cmd_kept", bus.cmd, 16'h3456);
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      repeat (2) @(negedge clk);
      check_output("stop_next_cmd", bus.cmd, 16'h0001);
      check_output("stop_next_rdy", {15'd0, bus.cmd_rdy}, 16'd1);

      // Reset in the middle of the lower byte of 0xBEEF
      send_byte(8'hBE, 1'b1);
      fork
         send_byte(8'hEF, 1'b1);
         begin
            repeat (BAUD * 5) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check_output("midrst_cmd", bus.cmd, 16'h0000);
            check_output("midrst_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
         end
      join
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (BAUD) @(negedge clk);
      check_output("midrst_cmd_after", bus.cmd, 16'h0000);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      repeat (2) @(negedge clk);
      check_output("midrst_next_cmd", bus.cmd, 16'h0102);
      check_output("midrst_next_rdy", {15'd0, bus.cmd_rdy}, 16'd1);

      // Short low glitch on RX must not start a byte
      r0 = rdy_count;
      e0 = err_count;
      bus.RX = 1'b0;
      repeat (BAUD / 4) @(negedge clk);
      bus.RX = 1'b1;
      repeat (2 * BAUD) @(negedge clk);
      check_output("glitch_no_rdy", 16'(rdy_count - r0), 16'd0);
      check_output("glitch_no_err", 16'(err_count - e0), 16'd0);
      send_byte(8'h7E, 1'b1);
      send_byte(8'h81, 1'b1);
      repeat (2) @(negedge clk);
      check_output("glitch_next_cmd", bus.cmd, 16'h7E81);
      check_output("glitch_rdy_count", 16'(rdy_count - r0), 16'd2);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
